// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: FSM states, command encodings, status
// flag bundle and the single-operand command classifiers.
package alu_pipe_pkg;

  // Width of the decoded opcode field; command bits above it must be zero.
  localparam int unsigned OpW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWaitA,
    StWaitB,
    StExec,
    StMul2
  } state_e;

  typedef enum logic [OpW-1:0] {
    ArAdd    = 4'd0,
    ArSub    = 4'd1,
    ArAddCin = 4'd2,
    ArSubCin = 4'd3,
    ArIncA   = 4'd4,
    ArDecA   = 4'd5,
    ArIncB   = 4'd6,
    ArDecB   = 4'd7,
    ArCmp    = 4'd8,
    ArMulInc = 4'd9,
    ArMulShl = 4'd10
  } arith_cmd_e;

  typedef enum logic [OpW-1:0] {
    LgAnd  = 4'd0,
    LgNand = 4'd1,
    LgOr   = 4'd2,
    LgNor  = 4'd3,
    LgXor  = 4'd4,
    LgXnor = 4'd5,
    LgNotA = 4'd6,
    LgNotB = 4'd7,
    LgShrA = 4'd8,
    LgShlA = 4'd9,
    LgShrB = 4'd10,
    LgShlB = 4'd11,
    LgRolA = 4'd12,
    LgRorA = 4'd13
  } logic_cmd_e;

  typedef struct packed {
    logic cout;
    logic oflow;
    logic g;
    logic e;
    logic l;
    logic err;
  } flags_t;

  // Commands that only need operand A and may execute without B.
  function automatic logic is_a_only(input logic mode, input logic [OpW-1:0] op);
    logic r;
    if (mode) begin
      r = (op == ArIncA) || (op == ArDecA);
    end else begin
      r = (op == LgNotA) || (op == LgShrA) || (op == LgShlA);
    end
    return r;
  endfunction

  // Commands that only need operand B and may execute without A.
  function automatic logic is_b_only(input logic mode, input logic [OpW-1:0] op);
    logic r;
    if (mode) begin
      r = (op == ArIncB) || (op == ArDecB);
    end else begin
      r = (op == LgNotB) || (op == LgShrB) || (op == LgShlB);
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// One-register pipelined unsigned multiplier, DW x DW -> 2*DW.
module alu_pipe_mul #(
  parameter int unsigned DW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic [2*DW-1:0] p_o
);

  localparam int unsigned W2 = 2 * DW;

  logic [W2-1:0] p_d, p_q;

  // Full-width product of the zero-extended operands.
  always_comb begin
    p_d = W2'(a_i) * W2'(b_i);
  end

  // Product register, loaded only when the top enables it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/alu_pipe.sv
// Operand-collecting ALU: gathers A/B (possibly on different cycles, with a
// timeout), executes one arithmetic or logic command and pulses res_valid_o.
// Multiplies take an extra cycle through alu_pipe_mul.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ce_i,
  input  logic [1:0]      inp_valid_i,
  input  logic [DW-1:0]   opa_i,
  input  logic [DW-1:0]   opb_i,
  input  logic            cin_i,
  input  logic            mode_i,
  input  logic [CW-1:0]   cmd_i,
  output logic            ready_o,
  output logic            res_valid_o,
  output logic [2*DW-1:0] res_o,
  output logic            cout_o,
  output logic            oflow_o,
  output logic            g_o,
  output logic            e_o,
  output logic            l_o,
  output logic            err_o
);

  localparam int unsigned W2   = 2 * DW;
  localparam int unsigned ShW  = $clog2(DW);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic            mode_q, mode_d, cin_q, cin_d;
  logic [W2-1:0]   res_q, res_d;
  flags_t          flags_q, flags_d;
  logic            res_valid_q, res_valid_d;

  // Opcode decode of the latched and incoming commands.
  logic [OpW-1:0]  op_q;
  logic            cmd_wide_q;
  logic            in_a_only, in_b_only;

  assign op_q       = OpW'(cmd_q);
  assign cmd_wide_q = |(cmd_q >> OpW);
  assign in_a_only  = ~(|(cmd_i >> OpW)) & is_a_only(mode_i, OpW'(cmd_i));
  assign in_b_only  = ~(|(cmd_i >> OpW)) & is_b_only(mode_i, OpW'(cmd_i));

  // Single-cycle datapath over the latched operands.
  logic [W2-1:0]   a_ext, b_ext, cin_ext;
  logic [ShW-1:0]  rot_sh;
  logic            rot_err;
  logic [DW-1:0]   rol_a, ror_a, lg_res;
  logic [W2-1:0]   alu_res;
  flags_t          alu_flags;
  logic            alu_is_mul;

  assign a_ext   = W2'(a_q);
  assign b_ext   = W2'(b_q);
  assign cin_ext = W2'(cin_q);
  assign rot_sh  = b_q[ShW-1:0];
  assign rot_err = |(b_q >> ShW);
  assign rol_a   = DW'(({a_q, a_q} << rot_sh) >> DW);
  assign ror_a   = DW'({a_q, a_q} >> rot_sh);

  // Multiplier: both commands reduce to A*B; the correction is applied after.
  logic [W2-1:0]   mul_p, mul_res;
  logic            mul_en;

  assign mul_en  = ce_i & (state_q == StExec) & alu_is_mul;
  assign mul_res = (op_q == ArMulInc) ? (mul_p + a_ext + b_ext + W2'(1)) : (mul_p << 1);

  alu_pipe_mul #(
    .DW (DW)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (mul_en),
    .a_i    (a_q),
    .b_i    (b_q),
    .p_o    (mul_p)
  );

  // Command decode: result, flags and multiply detection for EXEC.
  always_comb begin
    alu_res    = '0;
    alu_flags  = '0;
    alu_is_mul = 1'b0;
    lg_res     = '0;
    if (cmd_wide_q) begin
      alu_flags.err = 1'b1;
    end else if (mode_q) begin
      case (op_q)
        ArAdd: begin
          alu_res        = a_ext + b_ext;
          alu_flags.cout = alu_res[DW];
        end
        ArSub: begin
          alu_res         = a_ext - b_ext;
          alu_flags.oflow = (a_q < b_q);
        end
        ArAddCin: begin
          alu_res        = a_ext + b_ext + cin_ext;
          alu_flags.cout = alu_res[DW];
        end
        ArSubCin: begin
          alu_res         = a_ext - b_ext - cin_ext;
          alu_flags.oflow = (a_ext < (b_ext + cin_ext));
        end
        ArIncA: begin
          alu_res        = a_ext + W2'(1);
          alu_flags.cout = alu_res[DW];
        end
        ArDecA: begin
          alu_res         = a_ext - W2'(1);
          alu_flags.oflow = (a_q == '0);
        end
        ArIncB: begin
          alu_res        = b_ext + W2'(1);
          alu_flags.cout = alu_res[DW];
        end
        ArDecB: begin
          alu_res         = b_ext - W2'(1);
          alu_flags.oflow = (b_q == '0);
        end
        ArCmp: begin
          alu_flags.g = (a_q > b_q);
          alu_flags.e = (a_q == b_q);
          alu_flags.l = (a_q < b_q);
        end
        ArMulInc, ArMulShl: alu_is_mul = 1'b1;
        default: alu_flags.err = 1'b1;
      endcase
    end else begin
      case (op_q)
        LgAnd:  lg_res = a_q & b_q;
        LgNand: lg_res = ~(a_q & b_q);
        LgOr:   lg_res = a_q | b_q;
        LgNor:  lg_res = ~(a_q | b_q);
        LgXor:  lg_res = a_q ^ b_q;
        LgXnor: lg_res = ~(a_q ^ b_q);
        LgNotA: lg_res = ~a_q;
        LgNotB: lg_res = ~b_q;
        LgShrA: lg_res = {1'b0, a_q[DW-1:1]};
        LgShlA: lg_res = {a_q[DW-2:0], 1'b0};
        LgShrB: lg_res = {1'b0, b_q[DW-1:1]};
        LgShlB: lg_res = {b_q[DW-2:0], 1'b0};
        LgRolA: begin
          lg_res        = rol_a;
          alu_flags.err = rot_err;
        end
        LgRorA: begin
          lg_res        = ror_a;
          alu_flags.err = rot_err;
        end
        default: alu_flags.err = 1'b1;
      endcase
      alu_res = {{DW{1'b0}}, lg_res};
    end
  end

  // FSM next state, operand capture, timeout and result/flag registration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cmd_d       = cmd_q;
    mode_d      = mode_q;
    cin_d       = cin_q;
    res_d       = res_q;
    flags_d     = flags_q;
    res_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (inp_valid_i != 2'b00) begin
          cmd_d  = cmd_i;
          mode_d = mode_i;
          cin_d  = cin_i;
          cnt_d  = '0;
          if (inp_valid_i[0]) a_d = opa_i;
          if (inp_valid_i[1]) b_d = opb_i;
          case (inp_valid_i)
            2'b11:   state_d = StExec;
            2'b01:   state_d = in_a_only ? StExec : StWaitB;
            default: state_d = in_b_only ? StExec : StWaitA;
          endcase
        end
      end
      StWaitA, StWaitB: begin
        // The missing operand wins even on the final timeout cycle.
        if ((state_q == StWaitA) && inp_valid_i[0]) begin
          a_d     = opa_i;
          state_d = StExec;
        end else if ((state_q == StWaitB) && inp_valid_i[1]) begin
          b_d     = opb_i;
          state_d = StExec;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          res_d       = '0;
          flags_d     = '0;
          flags_d.err = 1'b1;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StExec: begin
        if (alu_is_mul) begin
          state_d = StMul2;
        end else begin
          res_d       = alu_res;
          flags_d     = alu_flags;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StMul2: begin
        res_d       = mul_res;
        flags_d     = '0;
        res_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; clock enable freezes everything, reset does not wait for it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      res_valid_q <= 1'b0;
    end else if (ce_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cmd_q       <= cmd_d;
      mode_q      <= mode_d;
      cin_q       <= cin_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign ready_o     = (state_q == StIdle) || (state_q == StWaitA) || (state_q == StWaitB);
  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign cout_o      = flags_q.cout;
  assign oflow_o     = flags_q.oflow;
  assign g_o         = flags_q.g;
  assign e_o         = flags_q.e;
  assign l_o         = flags_q.l;
  assign err_o       = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized self-checking bench for alu_pipe against a behavioural model.
module tb_alu_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni, ce_i;
  logic [1:0]  inp_valid_i;
  logic [7:0]  opa_i, opb_i;
  logic        cin_i, mode_i;
  logic [3:0]  cmd_i;
  logic        ready_o, res_valid_o;
  logic [15:0] res_o;
  logic        cout_o, oflow_o, g_o, e_o, l_o, err_o;

  int    n_checks = 0;
  int    n_errors = 0;
  string ctx = "";

  always #5 clk_i = ~clk_i;

  alu_pipe #(
    .DW      (8),
    .CW      (4),
    .TIMEOUT (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ce_i        (ce_i),
    .inp_valid_i (inp_valid_i),
    .opa_i       (opa_i),
    .opb_i       (opb_i),
    .cin_i       (cin_i),
    .mode_i      (mode_i),
    .cmd_i       (cmd_i),
    .ready_o     (ready_o),
    .res_valid_o (res_valid_o),
    .res_o       (res_o),
    .cout_o      (cout_o),
    .oflow_o     (oflow_o),
    .g_o         (g_o),
    .e_o         (e_o),
    .l_o         (l_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [15:0] res;
    logic cout, oflow, g, e, l, err;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (%s): got %0h expected %0h", tag, ctx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit a_only(input bit m, input int c);
    return m ? (c == 4 || c == 5) : (c == 6 || c == 8 || c == 9);
  endfunction

  function automatic bit b_only(input bit m, input int c);
    return m ? (c == 6 || c == 7) : (c == 7 || c == 10 || c == 11);
  endfunction

  // Result of one command computed with plain integer arithmetic.
  function automatic exp_t model(input bit m, input int c, input int a, input int b, input bit ci);
    exp_t e;
    int   r;
    int   sh;
    e  = '0;
    r  = 0;
    sh = b % 8;
    if (m) begin
      case (c)
        0:  begin r = a + b; e.cout = r[8]; end
        1:  begin r = a - b; e.oflow = (a < b); end
        2:  begin r = a + b + int'(ci); e.cout = r[8]; end
        3:  begin r = a - b - int'(ci); e.oflow = (a < b + int'(ci)); end
        4:  begin r = a + 1; e.cout = r[8]; end
        5:  begin r = a - 1; e.oflow = (a == 0); end
        6:  begin r = b + 1; e.cout = r[8]; end
        7:  begin r = b - 1; e.oflow = (b == 0); end
        8:  begin e.g = (a > b); e.e = (a == b); e.l = (a < b); end
        9:  r = (a + 1) * (b + 1);
        10: r = (a * 2) * b;
        default: e.err = 1'b1;
      endcase
    end else begin
      case (c)
        0:  r = a & b;
        1:  r = ~(a & b) & 255;
        2:  r = a | b;
        3:  r = ~(a | b) & 255;
        4:  r = a ^ b;
        5:  r = ~(a ^ b) & 255;
        6:  r = ~a & 255;
        7:  r = ~b & 255;
        8:  r = a / 2;
        9:  r = (a * 2) & 255;
        10: r = b / 2;
        11: r = (b * 2) & 255;
        12: begin r = ((a << sh) | (a >> (8 - sh))) & 255; e.err = (b > 7); end
        13: begin r = ((a >> sh) | (a << (8 - sh))) & 255; e.err = (b > 7); end
        default: e.err = 1'b1;
      endcase
    end
    e.res = r[15:0];
    return e;
  endfunction

  // pat: 0 both operands together, 1 A then B after gap, 2 B then A after gap,
  // 3 A only and B never arrives.
  task automatic do_op(input bit m, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input bit ci, input int pat, input int gap);
    exp_t ex;
    int   lat, cyc;
    bit   first_a, solo, tmo, mul;
    ctx     = $sformatf("m%0d c%0d a%02h b%02h ci%0d p%0d g%0d", m, c, a, b, ci, pat, gap);
    ex      = model(m, int'(c), int'(a), int'(b), ci);
    first_a = (pat != 2);
    solo    = (pat == 0) || (first_a ? a_only(m, int'(c)) : b_only(m, int'(c)));
    tmo     = (pat == 3) && !solo;
    mul     = m && (c == 4'd9 || c == 4'd10);
    if (tmo) begin
      ex     = '0;
      ex.err = 1'b1;
    end
    lat = tmo ? 17 : (mul ? 3 : 2);
    mode_i = m; cmd_i = c; cin_i = ci; opa_i = a; opb_i = b;
    inp_valid_i = (pat == 0) ? 2'b11 : (first_a ? 2'b01 : 2'b10);
    if (!solo && !tmo) begin
      for (int k = 1; k <= gap; k++) begin
        step();
        if (k == 1) check("ready_wait", 32'(ready_o), 32'd1);
        cmd_i = 4'($urandom); mode_i = 1'($urandom); cin_i = 1'($urandom);
        if (first_a) begin
          opa_i = 8'($urandom);
          if (k < gap) inp_valid_i = {1'b0, 1'($urandom)};
          else begin opb_i = b; inp_valid_i = {1'b1, 1'($urandom)}; end
        end else begin
          opb_i = 8'($urandom);
          if (k < gap) inp_valid_i = {1'($urandom), 1'b0};
          else begin opa_i = a; inp_valid_i = {1'($urandom), 1'b1}; end
        end
      end
    end
    cyc = 0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (res_valid_o) break;
      if (cyc == 1 && !tmo) check("ready_busy", 32'(ready_o), 32'd0);
      cmd_i = 4'($urandom); mode_i = 1'($urandom); cin_i = 1'($urandom);
      opa_i = 8'($urandom); opb_i = 8'($urandom);
      inp_valid_i = tmo ? {1'b0, 1'($urandom)} : 2'b11;
    end
    inp_valid_i = 2'b00;
    check("latency", cyc, lat);
    check("res", 32'(res_o), 32'(ex.res));
    check("cout", 32'(cout_o), 32'(ex.cout));
    check("oflow", 32'(oflow_o), 32'(ex.oflow));
    check("gel", 32'({g_o, e_o, l_o}), 32'({ex.g, ex.e, ex.l}));
    check("err", 32'(err_o), 32'(ex.err));
    check("ready_done", 32'(ready_o), 32'd1);
    step();
    check("rv_pulse", 32'(res_valid_o), 32'd0);
    check("res_hold", 32'(res_o), 32'(ex.res));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rv"}, 32'(res_valid_o), 32'd0);
    check({tag, "_res"}, 32'(res_o), 32'd0);
    check({tag, "_flags"}, 32'({cout_o, oflow_o, g_o, e_o, l_o, err_o}), 32'd0);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pr, pat;
    rst_ni = 1'b0; ce_i = 1'b1; inp_valid_i = 2'b00;
    opa_i = '0; opb_i = '0; cin_i = 1'b0; mode_i = 1'b0; cmd_i = '0;
    #3;
    ctx = "reset";
    check_cleared("reset");
    #9 rst_ni = 1'b1;
    step();

    do_op(1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 0, 0);
    do_op(1'b1, 4'd9,  8'h03, 8'h04, 1'b0, 0, 0);
    do_op(1'b1, 4'd1,  8'h05, 8'h09, 1'b0, 1, 4);
    do_op(1'b1, 4'd0,  8'h10, 8'h00, 1'b0, 3, 0);
    do_op(0,    4'd12, 8'h81, 8'h11, 1'b0, 0, 0);
    do_op(0,    4'd13, 8'h81, 8'h03, 1'b0, 0, 0);
    do_op(1'b1, 4'd8,  8'h40, 8'h40, 1'b0, 0, 0);
    do_op(1'b1, 4'd8,  8'h41, 8'h40, 1'b0, 2, 2);
    do_op(1'b1, 4'd8,  8'h3F, 8'h40, 1'b0, 1, 1);
    do_op(1'b1, 4'd3,  8'h05, 8'h05, 1'b1, 0, 0);
    do_op(1'b1, 4'd2,  8'h7F, 8'h80, 1'b1, 1, 16);
    do_op(1'b1, 4'd6,  8'h00, 8'hFF, 1'b0, 2, 3);
    do_op(0,    4'd6,  8'h5A, 8'h00, 1'b0, 1, 5);
    do_op(1'b1, 4'd10, 8'hFF, 8'hFF, 1'b0, 0, 0);
    do_op(1'b1, 4'd15, 8'h12, 8'h34, 1'b0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      pr  = $urandom_range(0, 9);
      pat = (pr < 4) ? 0 : (pr < 7) ? 1 : (pr < 9) ? 2 : 3;
      do_op(1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            pat, $urandom_range(1, 16));
    end

    // Clock enable low stalls EXEC and freezes the result pulse.
    ctx = "ce";
    mode_i = 1'b1; cmd_i = 4'd2; opa_i = 8'h7F; opb_i = 8'h80; cin_i = 1'b1;
    inp_valid_i = 2'b11;
    step();
    inp_valid_i = 2'b00; ce_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ce_stall_rv", 32'(res_valid_o), 32'd0);
      check("ce_stall_ready", 32'(ready_o), 32'd0);
    end
    ce_i = 1'b1;
    step();
    check("ce_rv", 32'(res_valid_o), 32'd1);
    check("ce_res", 32'(res_o), 32'h100);
    check("ce_cout", 32'(cout_o), 32'd1);
    ce_i = 1'b0;
    step();
    check("ce_freeze_rv", 32'(res_valid_o), 32'd1);
    ce_i = 1'b1;
    step();
    check("ce_rv_drop", 32'(res_valid_o), 32'd0);

    // Reset in MUL2 clears outputs at once and kills the pending result.
    ctx = "rst_mul2";
    mode_i = 1'b1; cmd_i = 4'd10; opa_i = 8'h21; opb_i = 8'h33; cin_i = 1'b0;
    inp_valid_i = 2'b11;
    step();
    inp_valid_i = 2'b00;
    step();
    #2 rst_ni = 1'b0;
    #1;
    check_cleared("rst_mul2");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("no_late_rv", 32'(res_valid_o), 32'd0);
    end
    do_op(1'b1, 4'd10, 8'h21, 8'h33, 1'b0, 0, 0);

    // Reset acts even with the clock enable low.
    ctx = "rst_ce0";
    ce_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check_cleared("rst_ce0");
    #2 rst_ni = 1'b1;
    ce_i = 1'b1;
    step();
    do_op(1'b1, 4'd4, 8'hFF, 8'h00, 1'b0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DW, default 8: operand width, SHALL be ≥4 and a power of two.
REQ-002 Parameter CW, default 4: command width.
REQ-003 Parameter TIMEOUT, default 16: cycles to wait for a missing second operand.
REQ-004 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST  in  1  asynchronous, active-low reset.
REQ-006 CE  in  1  clock enable; low SHALL freeze all state and outputs.
REQ-007 INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
REQ-008 OPA, OPB  in  DW  operands.
REQ-009 CIN  in  1  carry in.
REQ-010 MODE  in  1  1 = arithmetic, 0 = logic.
REQ-011 CMD  in  CW  operation code.
REQ-012 READY  out  1  high when a new operand is accepted (IDLE or WAIT).
REQ-013 RES_VALID  out  1  one-cycle pulse qualifying RES and all flags.
REQ-014 RES  out  2*DW  result, zero-extended.
REQ-015 COUT, OFLOW, G, E, L, ERR  out  1 each  status flags; never Z or X.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_A, WAIT_B, EXEC, MUL2.
REQ-017 In IDLE, INP_VALID=11 SHALL latch OPA, OPB, CMD, MODE and CIN, then go to EXEC.
REQ-018 In IDLE, INP_VALID=01 SHALL latch OPA/CMD/MODE/CIN and go to EXEC if the command is A-only (INC_A, DEC_A, NOT_A, SHL_A, SHR_A), else to WAIT_B.
REQ-019 INP_VALID=10 in IDLE SHALL mirror REQ-018 for B (B-only: INC_B, DEC_B, NOT_B, SHL_B, SHR_B; else WAIT_A).
REQ-020 WAIT_x SHALL accept the missing operand when its INP_VALID bit is set, ignoring the other bit and any new CMD, then go to EXEC.
REQ-021 The WAIT counter SHALL reset to 0 on entry and increment each CE cycle without the missing operand; at TIMEOUT it SHALL emit RES_VALID with ERR=1, RES=0 and return to IDLE.
REQ-022 EXEC SHALL register the result with RES_VALID=1 on the next edge (latency 1 from pair completion) and return to IDLE; READY=0 in EXEC/MUL2, so inputs are ignored there.
REQ-023 Multiply commands SHALL pass EXEC→MUL2 and assert RES_VALID one cycle later (latency 2).
REQ-024 Arithmetic CMD: 0 A+B; 1 A−B; 2 A+B+CIN; 3 A−B−CIN; 4 A+1; 5 A−1; 6 B+1; 7 B−1; 8 compare; 9 (A+1)*(B+1); 10 (A<<1)*B, mod 2^(2*DW).
REQ-025 COUT SHALL be sum bit DW for CMD 0/2/4/6; OFLOW SHALL be the borrow for CMD 1/3/5/7.
REQ-026 Compare SHALL set exactly one of G/E/L and RES=0.
REQ-027 Logic CMD: 0 AND; 1 NAND; 2 OR; 3 NOR; 4 XOR; 5 XNOR; 6 NOT_A; 7 NOT_B; 8 SHR_A; 9 SHL_A; 10 SHR_B; 11 SHL_B, each by 1; 12 ROL A; 13 ROR A.
REQ-028 Rotate amount SHALL be B[log2(DW)-1:0]; any nonzero higher B bit SHALL set ERR=1 and still rotate.
REQ-029 Unlisted CMD values SHALL return RES=0, ERR=1.
REQ-030 Flags not defined for an operation SHALL be 0; every output SHALL hold between RES_VALID pulses.

Reset
REQ-031 RST low SHALL immediately force state IDLE, counter 0, all latched operands 0, RES=0, all flags 0, RES_VALID=0 and READY=1, including mid-WAIT or mid-MUL2, with no late RES_VALID.
REQ-032 RST low SHALL take effect whatever the value of CE.

Structure
REQ-033 Package alu_pipe_pkg SHALL hold the state enum, the arithmetic and logic command enums, and the A-only/B-only classification functions.
REQ-034 The multiplier SHALL be a separate sub-module, alu_pipe_mul (one-register pipelined DW×DW→2*DW); all other logic SHALL be in alu_pipe.

Verification
REQ-035 MODE=1 CMD=0, 11 with A=0xFF, B=0x01 -> one cycle later RES_VALID, RES=0x0100, COUT=1.
REQ-036 MODE=1 CMD=9, A=3, B=4 -> RES_VALID two cycles after capture, RES=20; inputs during EXEC/MUL2 ignored.
REQ-037 MODE=1 CMD=1, 01 A=5, then 10 B=9 four cycles later -> RES=0xFFFC (two's complement, width 16), OFLOW=1.
REQ-038 01 A=0x10 CMD=0, no OPB for 16 cycles -> RES_VALID with ERR=1, RES=0, READY=1 afterwards.
REQ-039 MODE=0 CMD=12, A=0x81, B=0x11 -> RES=0x03, ERR=1.
REQ-040 RST low during MUL2 -> all outputs 0 immediately, no RES_VALID after release.
